// File: rtl/output_ctrl_if.sv
// Sample-in / result-out handshake bundle of the FIR output controller.
// master: the side that supplies sums and consumes results (upstream tree + downstream sink).
// slave: the output controller itself.
//   sum_in / sum_valid        : signed accumulated sum from the tap adder tree
//   filter_out / out_valid    : FIFO head sample and its valid flag
//   out_ready                 : downstream accept for filter_out
interface output_ctrl_if #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 8
);
    logic signed [IN_W-1:0]  sum_in;
    logic                    sum_valid;
    logic signed [OUT_W-1:0] filter_out;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output sum_in,
        output sum_valid,
        output out_ready,
        input  filter_out,
        input  out_valid
    );

    modport slave (
        input  sum_in,
        input  sum_valid,
        input  out_ready,
        output filter_out,
        output out_valid
    );
endinterface

// File: rtl/output_ctrl.sv
// Round/saturate FIR sums to sfix8_En7, buffer in a show-ahead FIFO, hand off over valid/ready.
// Latency: a sum presented in cycle 0 is at filter_out with out_valid in cycle 2 (FIFO empty, no bypass).
// Backpressure: out_ready low fills the DEPTH-entry FIFO; further samples are dropped and counted.
//
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   clk_enable      : qualifies sum_valid at the capture stage only; read side keeps running
//   bus (slave)     : sum_in/sum_valid in, filter_out/out_valid out, out_ready in
//   overflow        : sticky, set by any saturation clamp
//   drop_cnt        : saturating count of samples lost to a full FIFO
//   fifo_level      : FIFO occupancy, 0..DEPTH
// Build option: define ROUND_CONVERGENT_EN for round-half-to-even; otherwise ties round toward +inf.
module output_ctrl #(
    parameter int IN_W     = 24,
    parameter int IN_FRAC  = 14,
    parameter int OUT_W    = 8,
    parameter int OUT_FRAC = 7,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_enable,
    output_ctrl_if.slave               bus,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int SH = IN_FRAC - OUT_FRAC;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] MINV = ~MAXV;   // -2^(OUT_W-1)

`ifdef ROUND_CONVERGENT_EN
    localparam logic [SH-1:0] HALF = SH'(1) << (SH - 1);
`endif

    // ------------------------------------------------------------------
    // Rounding and saturation (combinational ahead of stage 1)
    // ------------------------------------------------------------------
    logic signed [IN_W:0]  ext;     // one guard bit so the rounding increment cannot wrap
    logic signed [IN_W:0]  trunc;
    logic signed [IN_W:0]  rnd;
    logic                  inc;
    logic [OUT_W-1:0]      sat;
    logic                  clip;
`ifdef ROUND_CONVERGENT_EN
    logic [SH-1:0]         rem;
`endif

    always_comb begin
        ext   = {bus.sum_in[IN_W-1], bus.sum_in};
        trunc = ext >>> SH;
`ifdef ROUND_CONVERGENT_EN
        // Exact tie only rounds up when the truncated result is odd.
        rem   = ext[SH-1:0];
        inc   = rem[SH-1] & ((rem != HALF) | trunc[0]);
`else
        // floor((x + half) / 2^SH) == floor(x / 2^SH) + (top discarded bit)
        inc   = ext[SH-1];
`endif
        rnd   = trunc + {{IN_W{1'b0}}, inc};
        clip  = 1'b0;
        sat   = rnd[OUT_W-1:0];
        if (rnd > MAXV) begin
            sat  = MAXV[OUT_W-1:0];
            clip = 1'b1;
        end else if (rnd < MINV) begin
            sat  = MINV[OUT_W-1:0];
            clip = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture rounded value
    // ------------------------------------------------------------------
    logic             s1_v;
    logic [OUT_W-1:0] s1_d;
    logic             capture;

    assign capture = clk_enable & bus.sum_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v     <= 1'b0;
            s1_d     <= '0;
            overflow <= 1'b0;
        end else begin
            s1_v <= capture;
            if (capture) begin
                s1_d <= sat;
                if (clip) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: show-ahead FIFO
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             pop;
    logic             do_push;
    logic             drop;

    assign full    = (fifo_level == LW'(DEPTH));
    assign pop     = bus.out_valid & bus.out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign do_push = s1_v & (~full | pop);
    assign drop    = s1_v & full & ~pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_cnt   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= s1_d;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign bus.filter_out = mem[rd_ptr];
    assign bus.out_valid  = (fifo_level != '0);

endmodule

// File: tb/tb_output_ctrl.sv
// Self-checking bench for output_ctrl: rounding/saturation vector table fed through
// a scoreboard queue, plus hand-written latency, backpressure, full push/pop,
// clk_enable gating and asynchronous reset sequences.
module tb_output_ctrl;

`ifdef ROUND_CONVERGENT_EN
    localparam int EXP64   = 0;
    localparam int EXP320  = 2;
    localparam int EXPM192 = -2;
`else
    localparam int EXP64   = 1;
    localparam int EXP320  = 3;
    localparam int EXPM192 = -1;
`endif

    logic       clk;
    logic       reset;
    logic       clk_enable;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic [2:0] fifo_level;

    output_ctrl_if #(.IN_W(24), .OUT_W(8)) bus ();

    output_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .bus        (bus),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    typedef struct {
        int sum;
        int exp;
        bit ovf;
    } vec_t;

    vec_t vt[18];
    int   exp_q[$];
    int   total;
    int   bad;

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Runs at the negedge, where the handshake for the coming edge is stable.
    task automatic monitor();
        int e;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_out", int'(bus.filter_out), 9999);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", int'(bus.filter_out), e);
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_expect(input bit v, input string nm);
        @(negedge clk);
        check(nm, int'(bus.out_valid), int'(v));
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input bit v);
        bus.sum_in    = 24'(s);
        bus.sum_valid = v;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) begin
            cyc();
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        vt[0]  = '{128,       1,       1'b0};
        vt[1]  = '{64,        EXP64,   1'b0};
        vt[2]  = '{192,       2,       1'b0};
        vt[3]  = '{-64,       0,       1'b0};
        vt[4]  = '{0,         0,       1'b0};
        vt[5]  = '{320,       EXP320,  1'b0};
        vt[6]  = '{-192,      EXPM192, 1'b0};
        vt[7]  = '{100,       1,       1'b0};
        vt[8]  = '{-100,      -1,      1'b0};
        vt[9]  = '{16256,     127,     1'b0};
        vt[10] = '{16319,     127,     1'b0};
        vt[11] = '{-16384,    -128,    1'b0};
        vt[12] = '{-16448,    -128,    1'b0};
        vt[13] = '{20000,     127,     1'b1};
        vt[14] = '{-20000,    -128,    1'b1};
        vt[15] = '{0,         0,       1'b1};
        vt[16] = '{8388607,   127,     1'b1};
        vt[17] = '{-8388608,  -128,    1'b1};

        total = 0;
        bad   = 0;
        reset = 1'b1;
        clk_enable    = 1'b1;
        bus.sum_in    = '0;
        bus.sum_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        check("rst_filter_out", int'(bus.filter_out), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Latency: sample presented in cycle 0 is visible in cycle 2 only
        bus.out_ready = 1'b1;
        drive(128, 1'b1);
        exp_q.push_back(1);
        @(negedge clk);
        check("lat_c0", int'(bus.out_valid), 0);
        monitor();
        @(posedge clk);
        #1;
        drive(0, 1'b0);
        cyc_expect(1'b0, "lat_c1");
        cyc_expect(1'b1, "lat_c2");
        cyc_expect(1'b0, "lat_c3");
        check("lat_overflow", int'(overflow), 0);
        check("lat_q_empty", exp_q.size(), 0);

        // Rounding / saturation table, one sample at a time
        for (int i = 0; i < 18; i++) begin
            drive(vt[i].sum, 1'b1);
            exp_q.push_back(vt[i].exp);
            cyc();
            drive(0, 1'b0);
            drain();
            check($sformatf("ovf_vec%0d", i), int'(overflow), int'(vt[i].ovf));
        end

        // Back-to-back stream, one sample per cycle
        for (int k = -4; k < 4; k++) begin
            drive(k * 128, 1'b1);
            exp_q.push_back(k);
            cyc();
        end
        drive(0, 1'b0);
        drain();

        // Backpressure: 6 samples into a 4-deep FIFO
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            drive(k * 128, 1'b1);
            if (k <= 4) exp_q.push_back(k);
            cyc();
        end
        drive(0, 1'b0);
        cyc();
        cyc();
        check("bp_level", int'(fifo_level), 4);
        check("bp_drop_cnt", int'(drop_cnt), 2);
        check("bp_head", int'(bus.filter_out), 1);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc_expect(1'b1, $sformatf("bp_out%0d_valid", k));
        end
        cyc_expect(1'b0, "bp_empty");
        check("bp_q_empty", exp_q.size(), 0);

        // Full FIFO with simultaneous push and pop
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(k * 10 * 128, 1'b1);
            exp_q.push_back(k * 10);
            cyc();
        end
        drive(0, 1'b0);
        cyc();
        cyc();
        check("fpp_level_full", int'(fifo_level), 4);
        drive(50 * 128, 1'b1);
        exp_q.push_back(50);
        cyc_expect(1'b1, "fpp_push_c0");
        drive(0, 1'b0);
        bus.out_ready = 1'b1;
        cyc_expect(1'b1, "fpp_pushpop_c1");
        bus.out_ready = 1'b0;
        check("fpp_level_kept", int'(fifo_level), 4);
        check("fpp_drop_same", int'(drop_cnt), 2);
        check("fpp_head", int'(bus.filter_out), 20);
        bus.out_ready = 1'b1;
        drain();
        cyc_expect(1'b0, "fpp_empty");

        // clk_enable low blocks capture
        clk_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(7 * 128, 1'b1);
            cyc();
        end
        drive(0, 1'b0);
        clk_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc_expect(1'b0, "ce_no_out");
        end
        check("ce_level", int'(fifo_level), 0);

        // Asynchronous reset with three buffered entries and one in flight
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(k * 128, 1'b1);
            cyc();
        end
        drive(0, 1'b0);
        cyc();
        cyc();
        check("mid_level3", int'(fifo_level), 3);
        drive(9 * 128, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", int'(bus.out_valid), 0);
        check("mid_rst_level", int'(fifo_level), 0);
        check("mid_rst_drop", int'(drop_cnt), 0);
        check("mid_rst_ovf", int'(overflow), 0);
        exp_q.delete();
        drive(0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            cyc_expect(1'b0, "post_rst_idle");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
